// File: rtl/sub_rr_arb.sv
// Round-robin arbiter sharing one downstream path between NREQ requesters.
// Grants are held until release, bounded by MAX_HOLD, and separated by one GAP cycle.
module sub_rr_arb #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_valid,
    output logic            timeout,
    output logic [CW-1:0]   busy_cnt,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q, timeout_d;
    logic [CW-1:0]   busy_q, busy_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic            found;
    logic [IW-1:0]   win;
    int              idx;
    logic            own_done;
    logic            own_req;
    logic            hit_max;

    // Rotating search starting at ptr_q; the first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign own_done = done[gnt_id_q];
    assign own_req  = req[gnt_id_q];
    assign hit_max  = (busy_q == CW'(MAX_HOLD));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[win]  = 1'b1;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
                    busy_d      = CW'(1);
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (own_done || !own_req || hit_max) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    busy_d      = '0;
                    state_d     = GAP;
                    // A voluntary release (done or dropped req) is never reported as a timeout.
                    timeout_d   = hit_max && !own_done && own_req;
                    ptr_d       = (gnt_id_q == IW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
                end else if (busy_q != {CW{1'b1}}) begin
                    busy_d = busy_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign busy_cnt  = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sub_rr_arb.sv
// Directed bench for sub_rr_arb: expected per-cycle outputs are queued ahead of
// each clock and popped/compared when the DUT outputs settle after the edge.
module tb_sub_rr_arb;

    logic       clk;
    logic       reset_n;

    // Default build: NREQ=4, MAX_HOLD=8, CW=8
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic [7:0] busy_cnt;
    logic [1:0] state_dbg;

    // Small build: NREQ=3, MAX_HOLD=1, CW=4
    logic [2:0] req3;
    logic [2:0] done3;
    logic [2:0] gnt3;
    logic [1:0] gnt_id3;
    logic       gnt_valid3;
    logic       timeout3;
    logic [3:0] busy_cnt3;
    logic [1:0] state_dbg3;

    logic [15:0] exp_q[$];
    logic [10:0] exp3_q[$];

    int vectors;
    int miscompares;

    sub_rr_arb #(.NREQ(4), .MAX_HOLD(8), .CW(8)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .busy_cnt  (busy_cnt),
        .state_dbg (state_dbg)
    );

    sub_rr_arb #(.NREQ(3), .MAX_HOLD(1), .CW(4)) u_dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req3),
        .done      (done3),
        .gnt       (gnt3),
        .gnt_id    (gnt_id3),
        .gnt_valid (gnt_valid3),
        .timeout   (timeout3),
        .busy_cnt  (busy_cnt3),
        .state_dbg (state_dbg3)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mk(input logic [3:0] g, input logic [1:0] id,
                                       input logic v, input logic to, input logic [7:0] b);
        return {g, id, v, to, b};
    endfunction

    function automatic logic [10:0] mk3(input logic [2:0] g, input logic [1:0] id,
                                        input logic v, input logic to, input logic [3:0] b);
        return {g, id, v, to, b};
    endfunction

    // Scoreboard push helpers
    task automatic push(input logic [15:0] e);
        exp_q.push_back(e);
    endtask

    // Full grant of `len` cycles, followed by the GAP cycle and the IDLE cycle.
    task automatic push_grant(input int owner, input int len, input logic to);
        logic [3:0] g;
        g = 4'b0001 << owner;
        for (int b = 1; b <= len; b++) begin
            push(mk(g, 2'(owner), 1'b1, 1'b0, 8'(b)));
        end
        push(mk(4'b0000, 2'(owner), 1'b0, to, 8'd0));
        push(mk(4'b0000, 2'(owner), 1'b0, 1'b0, 8'd0));
    endtask

    task automatic check_now(input string tag);
        logic [15:0] obs;
        logic [15:0] e;
        vectors++;
        obs = {gnt, gnt_id, gnt_valid, timeout, busy_cnt};
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected entry queued, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed gnt=%b id=%0d v=%b to=%b busy=%0d, expected gnt=%b id=%0d v=%b to=%b busy=%0d",
                       tag, obs[15:12], obs[11:10], obs[9], obs[8], obs[7:0],
                       e[15:12], e[11:10], e[9], e[8], e[7:0]);
            end
        end
    endtask

    task automatic check3_now(input string tag);
        logic [10:0] obs;
        logic [10:0] e;
        vectors++;
        obs = {gnt3, gnt_id3, gnt_valid3, timeout3, busy_cnt3};
        if (exp3_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: no expected entry queued, observed %h", tag, obs);
        end else begin
            e = exp3_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed gnt=%b id=%0d v=%b to=%b busy=%0d, expected gnt=%b id=%0d v=%b to=%b busy=%0d",
                       tag, obs[10:8], obs[7:6], obs[5], obs[4], obs[3:0],
                       e[10:8], e[7:6], e[5], e[4], e[3:0]);
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    task automatic tick3(input string tag);
        @(posedge clk);
        #1;
        check3_now(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick(tag);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        req         = '0;
        done        = '0;
        req3        = '0;
        done3       = '0;

        // Reset values
        #2;
        push(mk(4'b0000, 2'd0, 1'b0, 1'b0, 8'd0));
        check_now("reset");
        exp3_q.push_back(mk3(3'b000, 2'd0, 1'b0, 1'b0, 4'd0));
        check3_now("reset3");
        @(negedge clk);
        reset_n = 1'b1;
        push(mk(4'b0000, 2'd0, 1'b0, 1'b0, 8'd0));
        tick("idle_no_req");

        // All requesting: rotation 0,1,2,3,0 with timeouts and 2-cycle spacing
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_grant(k % 4, 8, 1'b1);
            run(10, "rotate_all");
        end
        req = 4'b0000;

        // Single requester released by done at grant cycle 3, then re-granted
        req = 4'b0100;
        push(mk(4'b0100, 2'd2, 1'b1, 1'b0, 8'd1));
        tick("done_c1");
        push(mk(4'b0100, 2'd2, 1'b1, 1'b0, 8'd2));
        tick("done_c2");
        push(mk(4'b0100, 2'd2, 1'b1, 1'b0, 8'd3));
        tick("done_c3");
        done = 4'b0100;
        push(mk(4'b0000, 2'd2, 1'b0, 1'b0, 8'd0));
        tick("done_gap");
        done = 4'b0000;
        push(mk(4'b0000, 2'd2, 1'b0, 1'b0, 8'd0));
        tick("done_idle");
        push(mk(4'b0100, 2'd2, 1'b1, 1'b0, 8'd1));
        tick("regrant");
        req = 4'b0000;
        push(mk(4'b0000, 2'd2, 1'b0, 1'b0, 8'd0));
        tick("req_drop_gap");
        push(mk(4'b0000, 2'd2, 1'b0, 1'b0, 8'd0));
        tick("req_drop_idle");

        // Owner 1 ignores non-owner done/req; done on the MAX_HOLD cycle suppresses timeout
        req = 4'b0010;
        push(mk(4'b0010, 2'd1, 1'b1, 1'b0, 8'd1));
        tick("no_preempt");
        req = 4'b1011;
        push(mk(4'b0010, 2'd1, 1'b1, 1'b0, 8'd2));
        tick("no_preempt");
        done = 4'b1000;
        req  = 4'b0010;
        push(mk(4'b0010, 2'd1, 1'b1, 1'b0, 8'd3));
        tick("no_preempt");
        done = 4'b0000;
        for (int b = 4; b <= 8; b++) begin
            push(mk(4'b0010, 2'd1, 1'b1, 1'b0, 8'(b)));
            tick("no_preempt");
        end
        done = 4'b0010;
        push(mk(4'b0000, 2'd1, 1'b0, 1'b0, 8'd0));
        tick("done_beats_timeout");
        done = 4'b0000;
        req  = 4'b0000;
        push(mk(4'b0000, 2'd1, 1'b0, 1'b0, 8'd0));
        tick("done_beats_timeout_idle");

        // Async reset mid-grant with owner 2; pointer returns to 0
        req = 4'b1111;
        push(mk(4'b0100, 2'd2, 1'b1, 1'b0, 8'd1));
        tick("pre_rst");
        push(mk(4'b0100, 2'd2, 1'b1, 1'b0, 8'd2));
        tick("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        push(mk(4'b0000, 2'd0, 1'b0, 1'b0, 8'd0));
        check_now("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
        push(mk(4'b0001, 2'd0, 1'b1, 1'b0, 8'd1));
        tick("post_rst_grant0");
        req = 4'b0000;
        push(mk(4'b0000, 2'd0, 1'b0, 1'b0, 8'd0));
        tick("post_rst_gap");
        push(mk(4'b0000, 2'd0, 1'b0, 1'b0, 8'd0));
        tick("post_rst_idle");

        // NREQ=3, MAX_HOLD=1: one-cycle grants 0,1,2,0 each with a timeout pulse
        req3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp3_q.push_back(mk3(3'b001 << (k % 3), 2'(k % 3), 1'b1, 1'b0, 4'd1));
            exp3_q.push_back(mk3(3'b000, 2'(k % 3), 1'b0, 1'b1, 4'd0));
            exp3_q.push_back(mk3(3'b000, 2'(k % 3), 1'b0, 1'b0, 4'd0));
            tick3("small_grant");
            tick3("small_gap");
            tick3("small_idle");
        end
        req3 = 3'b000;

        vectors++;
        assert (exp_q.size() == 0 && exp3_q.size() == 0) else begin
            miscompares++;
            $error("FAIL leftover: observed %0d/%0d unconsumed entries, expected 0/0",
                   exp_q.size(), exp3_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sub_rr_arb.md
Name: sub_rr_arb

Overview:
- Round-robin arbiter that shares one downstream resource (shared bus / output mux) between the four sub-block requesters sub_a..sub_d in the top-level.
- Grants one requester at a time, holds the grant until that requester releases it, and bounds occupancy with a hold-timeout.
- Drives a one-hot grant and an encoded owner index that selects the shared-path mux.

Parameters:
NREQ, 4, number of requesters; 2..8; the encoded ID width is clog2(NREQ).
MAX_HOLD, 8, maximum grant length in cycles before forced release; 1..255.
CW, 8, hold-counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request level; bit i = requester i
done  input  NREQ  per-requester release pulse; only the owner's bit is honoured
gnt  output  NREQ  one-hot grant, registered
gnt_id  output  clog2(NREQ)  encoded owner index, registered; valid only while gnt_valid=1
gnt_valid  output  1  a grant is active (equals OR of gnt)
timeout  output  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD
busy_cnt  output  CW  cycles elapsed in the current grant, saturating

Behaviour:
- Reset (async assert, sync deassert on the next clk edge): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, busy_cnt=0, state=IDLE, priority pointer ptr=0.
- States: IDLE, GRANT, GAP.
- IDLE: if any req bit is set, select the first set bit searching ptr, ptr+1, ... modulo NREQ.
  - Next cycle: gnt/gnt_id show the winner, gnt_valid=1, busy_cnt=1, state=GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT: busy_cnt increments each cycle, saturating at 2^CW-1.
- Release conditions, evaluated every cycle on the owner only, at the cycle edge:
  - done[owner]=1, or
  - req[owner]=0, or
  - busy_cnt==MAX_HOLD; in this case only, timeout=1 for exactly the next cycle.
- On release:
  - gnt=0, gnt_valid=0, busy_cnt=0, state=GAP.
  - ptr is set to owner+1 modulo NREQ, so the last owner has lowest priority.
- If done and the timeout condition occur in the same cycle, done wins and timeout is not asserted.
- done or req changes on non-owner bits during GRANT are ignored; no preemption.
- GAP: exactly one dead cycle with no grant, guaranteeing bus turnaround. GAP always goes to IDLE.
- IDLE re-arbitrates the same cycle it is entered. Minimum spacing between grants is therefore 2 idle cycles (GAP plus IDLE decision).
- gnt is always one-hot or zero. gnt_id holds its last value while gnt_valid=0.
- Async reset asserted mid-grant: outputs clear immediately and ptr returns to 0.
- A requester whose req stays high is re-granted only after every other active requester has been served once. No starvation: the worst-case wait is (NREQ-1)*(MAX_HOLD+2) cycles.

Test Plan:
1. Reset, then req=4'b1111 with done held 0 -> grants in order 0,1,2,3,0. Each lasts 8 cycles and ends with timeout=1 for one cycle, and successive grants are spaced 2 cycles apart.
2. req=4'b0100 only; pulse done[2] at grant cycle 3 -> gnt=4'b0100 for 3 cycles, busy_cnt reads 1,2,3, timeout never asserts, and gnt re-asserts after the GAP+IDLE cycles if req[2] is still high.
3. Owner 1 holds the grant; pulse done[3] and drop req[0] -> grant to 1 unaffected, busy_cnt continues counting.
4. Assert done[owner] in the same cycle busy_cnt==MAX_HOLD -> release occurs, timeout stays 0.
5. Assert reset_n=0 asynchronously mid-grant with owner=2 -> gnt=0 and gnt_valid=0 before the next clk edge. After release with req=4'b1111, the first grant goes to 0.
6. NREQ=3, MAX_HOLD=1 build, req=3'b111 -> grants 0,1,2,0, each 1 cycle with timeout pulses, gnt_id cycling 0,1,2.
